// File: rtl/multdiv_ctrl_if.sv
// Bundles the request, iterative-unit and response signals of the mult/div controller.
// The master side is the execute stage plus the units. The slave side is multdiv_ctrl.
interface multdiv_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_mult;
    logic             req_div;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;

    logic [31:0]      unit_operandA;
    logic [31:0]      unit_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [31:0]      mult_result;
    logic             mult_exception;
    logic             mult_resultRDY;
    logic [31:0]      div_result;
    logic             div_exception;
    logic             div_resultRDY;

    logic             rsp_valid;
    logic [31:0]      rsp_result;
    logic             rsp_exception;
    logic             rsp_timeout;
    logic             rsp_is_div;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_ack;
    logic             busy;

    modport master (
        output req_mult, req_div, req_a, req_b, req_tag,
        input  req_ready,
        input  unit_operandA, unit_operandB, ctrl_MULT, ctrl_DIV,
        output mult_result, mult_exception, mult_resultRDY,
        output div_result, div_exception, div_resultRDY,
        input  rsp_valid, rsp_result, rsp_exception, rsp_timeout, rsp_is_div, rsp_tag,
        output rsp_ack,
        input  busy
    );

    modport slave (
        input  req_mult, req_div, req_a, req_b, req_tag,
        output req_ready,
        output unit_operandA, unit_operandB, ctrl_MULT, ctrl_DIV,
        input  mult_result, mult_exception, mult_resultRDY,
        input  div_result, div_exception, div_resultRDY,
        output rsp_valid, rsp_result, rsp_exception, rsp_timeout, rsp_is_div, rsp_tag,
        input  rsp_ack,
        output busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequences one mult/div op: latch operands, pulse start, wait for RDY or timeout.
// Start pulse 1 cycle after accept, response 1 cycle after RDY; a held response blocks new requests.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    multdiv_ctrl_if.slave     bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] tag_q;
    logic             is_div;
    logic [CNT_W-1:0] cnt;
    logic             ctrl_mult_q;
    logic             ctrl_div_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_result_q;
    logic             rsp_exc_q;
    logic             rsp_to_q;
    logic             rsp_is_div_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic             sel_rdy;
    logic [31:0]      sel_result;
    logic             sel_exc;

    // Only the unit that was started is listened to.
    assign sel_rdy    = is_div ? bus.div_resultRDY : bus.mult_resultRDY;
    assign sel_result = is_div ? bus.div_result    : bus.mult_result;
    assign sel_exc    = is_div ? bus.div_exception : bus.mult_exception;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            tag_q        <= '0;
            is_div       <= 1'b0;
            cnt          <= '0;
            ctrl_mult_q  <= 1'b0;
            ctrl_div_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_exc_q    <= 1'b0;
            rsp_to_q     <= 1'b0;
            rsp_is_div_q <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_mult | bus.req_div) begin
                        op_a        <= bus.req_a;
                        op_b        <= bus.req_b;
                        tag_q       <= bus.req_tag;
                        is_div      <= ~bus.req_mult;
                        ctrl_mult_q <= bus.req_mult;
                        ctrl_div_q  <= ~bus.req_mult;
                        state       <= START;
                    end
                end
                START: begin
                    // RDY during the start cycle belongs to a previous op and is dropped.
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (sel_rdy) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= sel_result;
                        rsp_exc_q    <= sel_exc;
                        rsp_to_q     <= 1'b0;
                        rsp_is_div_q <= is_div;
                        rsp_tag_q    <= tag_q;
                        state        <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_exc_q    <= 1'b1;
                        rsp_to_q     <= 1'b1;
                        rsp_is_div_q <= is_div;
                        rsp_tag_q    <= tag_q;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ack) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.unit_operandA = op_a;
    assign bus.unit_operandB = op_b;
    assign bus.ctrl_MULT     = ctrl_mult_q;
    assign bus.ctrl_DIV      = ctrl_div_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_exception = rsp_exc_q;
    assign bus.rsp_timeout   = rsp_to_q;
    assign bus.rsp_is_div    = rsp_is_div_q;
    assign bus.rsp_tag       = rsp_tag_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with simple latency-programmable multiplier/divider models.
module tb_multdiv_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    multdiv_ctrl_if #(.TAG_W(5)) bus ();

    multdiv_ctrl #(.TIMEOUT(40), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    int mult_pulses = 0;
    int div_pulses = 0;
    int m_lat = 17;
    int d_lat = 33;
    int m_cnt = -1;
    int d_cnt = -1;
    logic spur_mult = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.ctrl_MULT) begin
            mult_pulses = mult_pulses + 1;
            pulse_cyc = cyc;
        end
        if (bus.ctrl_DIV) begin
            div_pulses = div_pulses + 1;
            pulse_cyc = cyc;
        end
    end

    // Unit models: RDY is raised for one cycle m_lat/d_lat cycles after the start pulse.
    always @(negedge clock) begin
        if (!reset) begin
            m_cnt = -1;
            d_cnt = -1;
        end else begin
            if (bus.ctrl_MULT) m_cnt = 0;
            else if (m_cnt >= 0) m_cnt = m_cnt + 1;
            if (bus.ctrl_DIV) d_cnt = 0;
            else if (d_cnt >= 0) d_cnt = d_cnt + 1;
        end
        bus.mult_resultRDY = spur_mult || (m_cnt == m_lat);
        bus.mult_result    = (m_cnt == m_lat)
                             ? $signed(bus.unit_operandA) * $signed(bus.unit_operandB)
                             : 32'hDEADBEEF;
        bus.mult_exception = 1'b0;
        bus.div_resultRDY  = (d_cnt == d_lat);
        bus.div_exception  = (bus.unit_operandB == 32'd0);
        bus.div_result     = (d_cnt == d_lat && bus.unit_operandB != 32'd0)
                             ? $signed(bus.unit_operandA) / $signed(bus.unit_operandB)
                             : 32'hCAFEF00D;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        bus.req_mult = m;
        bus.req_div  = d;
        bus.req_a    = a;
        bus.req_b    = b;
        bus.req_tag  = tag;
        @(negedge clock);
        bus.req_mult = 1'b0;
        bus.req_div  = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int gap);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clock);
            n = n + 1;
        end
        chk({tag, "_seen"}, 32'(bus.rsp_valid), 32'd1);
        gap = cyc - pulse_cyc;
    endtask

    task automatic ack(input string tag);
        bus.rsp_ack = 1'b1;
        @(negedge clock);
        bus.rsp_ack = 1'b0;
        chk({tag, "_ackvld"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_ackrdy"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int gap;
        int seen;
        bus.req_mult = 1'b0;
        bus.req_div  = 1'b0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        bus.req_tag  = '0;
        bus.rsp_ack  = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ctrl",  32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
        chk("rst_opA",   bus.unit_operandA, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // 6 x 7, tag 3
        issue(1'b1, 1'b0, 32'd6, 32'd7, 5'd3);
        chk("mul_busy", 32'(bus.busy), 32'd1);
        wait_rsp("mul", gap);
        chk("mul_lat",    32'(gap), 32'd18);
        chk("mul_res",    bus.rsp_result, 32'd42);
        chk("mul_tag",    32'(bus.rsp_tag), 32'd3);
        chk("mul_isdiv",  32'(bus.rsp_is_div), 32'd0);
        chk("mul_exc",    32'(bus.rsp_exception), 32'd0);
        chk("mul_to",     32'(bus.rsp_timeout), 32'd0);
        chk("mul_npulse", 32'(mult_pulses), 32'd1);
        ack("mul");

        // 100 / 7 with a spurious multiplier RDY during WAIT
        issue(1'b0, 1'b1, 32'd100, 32'd7, 5'd9);
        repeat (5) @(negedge clock);
        spur_mult = 1'b1;
        repeat (3) @(negedge clock);
        spur_mult = 1'b0;
        wait_rsp("div", gap);
        chk("div_lat",    32'(gap), 32'd34);
        chk("div_res",    bus.rsp_result, 32'd14);
        chk("div_isdiv",  32'(bus.rsp_is_div), 32'd1);
        chk("div_tag",    32'(bus.rsp_tag), 32'd9);
        chk("div_npulse", 32'(div_pulses), 32'd1);
        chk("div_nomul",  32'(mult_pulses), 32'd1);
        ack("div");

        // mult and div requested together: multiply wins
        issue(1'b1, 1'b1, 32'd5, 32'd9, 5'd1);
        chk("both_ready", 32'(bus.req_ready), 32'd0);
        wait_rsp("both", gap);
        chk("both_res",    bus.rsp_result, 32'd45);
        chk("both_isdiv",  32'(bus.rsp_is_div), 32'd0);
        chk("both_nodiv",  32'(div_pulses), 32'd1);
        chk("both_ready2", 32'(bus.req_ready), 32'd0);

        // hold the response 5 cycles while a new request waits
        bus.req_mult = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req_a   = 32'(100 + i);
            bus.req_b   = 32'(200 + i);
            bus.req_tag = 5'(20 + i);
            @(negedge clock);
        end
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_res",   bus.rsp_result, 32'd45);
        chk("hold_tag",   32'(bus.rsp_tag), 32'd1);
        chk("hold_opA",   bus.unit_operandA, 32'd5);
        chk("hold_opB",   bus.unit_operandB, 32'd9);
        chk("hold_nmul",  32'(mult_pulses), 32'd2);
        bus.req_a   = 32'd11;
        bus.req_b   = 32'd13;
        bus.req_tag = 5'd2;
        bus.rsp_ack = 1'b1;
        @(negedge clock);
        bus.rsp_ack = 1'b0;
        chk("hold_idle",  32'(bus.req_ready), 32'd1);
        chk("hold_nmul2", 32'(mult_pulses), 32'd2);
        @(negedge clock);
        bus.req_mult = 1'b0;
        chk("hold_acc",   32'(bus.busy), 32'd1);
        wait_rsp("hold2", gap);
        chk("hold2_res",  bus.rsp_result, 32'd143);
        chk("hold2_tag",  32'(bus.rsp_tag), 32'd2);
        chk("hold2_nmul", 32'(mult_pulses), 32'd3);
        ack("hold2");

        // unit never answers
        m_lat = 1000;
        issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd4);
        wait_rsp("tmo", gap);
        chk("tmo_lat", 32'(gap), 32'd41);
        chk("tmo_res", bus.rsp_result, 32'd0);
        chk("tmo_exc", 32'(bus.rsp_exception), 32'd1);
        chk("tmo_to",  32'(bus.rsp_timeout), 32'd1);
        chk("tmo_tag", 32'(bus.rsp_tag), 32'd4);
        ack("tmo");
        m_lat = 17;

        // reset in the middle of WAIT
        issue(1'b1, 1'b0, 32'd8, 32'd8, 5'd5);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_busy",  32'(bus.busy), 32'd0);
        chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_ready", 32'(bus.req_ready), 32'd1);
        chk("mrst_opA",   bus.unit_operandA, 32'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.busy) seen = seen + 1;
        end
        chk("mrst_norsp", 32'(seen), 32'd0);

        issue(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 5'd6);
        wait_rsp("neg", gap);
        chk("neg_res", bus.rsp_result, 32'hFFFF_FFF4);
        chk("neg_tag", 32'(bus.rsp_tag), 32'd6);
        ack("neg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller between the execute stage and the shared iterative multiplier and divider units.
- Accepts one mult/div request at a time and latches its operands.
- Holds the unit operand buses stable for the whole operation, issues the single-cycle ctrl_MULT/ctrl_DIV start pulse, and waits for the unit's resultRDY, or times out.
- Returns the tagged result through a valid/ack handshake and provides busy for pipeline stall logic.

Parameters:
TIMEOUT, 40, max WAIT cycles before the operation is aborted (must exceed the worst-case unit latency of 33).
TAG_W, 5, width of the destination-register tag.

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
req_mult  in  1  request a multiply (sampled only in IDLE)
req_div  in  1  request a divide (sampled only in IDLE)
req_a  in  32  operand A
req_b  in  32  operand B
req_tag  in  TAG_W  destination tag
req_ready  out  1  high only in IDLE
unit_operandA  out  32  latched A driven to both units
unit_operandB  out  32  latched B driven to both units
ctrl_MULT  out  1  multiplier start pulse
ctrl_DIV  out  1  divider start pulse
mult_result  in  32  multiplier result
mult_exception  in  1  multiplier exception
mult_resultRDY  in  1  multiplier done
div_result  in  32  divider result
div_exception  in  1  divider exception
div_resultRDY  in  1  divider done
rsp_valid  out  1  response available
rsp_result  out  32  captured result
rsp_exception  out  1  unit exception OR timeout
rsp_timeout  out  1  response produced by timeout
rsp_is_div  out  1  response belongs to a divide
rsp_tag  out  TAG_W  tag of the response
rsp_ack  in  1  consumer accepts the response
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all latched operands, rsp_* fields, cycle counter and op select cleared to 0.
  - Outputs while reset is low or right after it: req_ready=1, busy=0, ctrl_*=0, rsp_valid=0.
- Reset mid-operation aborts the operation; no response is ever produced for it.
- States:
  - IDLE:
    - req_ready=1.
    - If req_mult|req_div at the clock edge: latch a, b, tag, and op (is_div=~req_mult; mult has priority when both are high, and the div request is dropped); go to START.
  - START, exactly 1 cycle:
    - ctrl_MULT=~is_div or ctrl_DIV=is_div is high for this cycle only.
    - Counter cleared; go to WAIT.
    - Any RDY seen in this cycle is stale and is ignored.
  - WAIT:
    - Counter increments every cycle.
    - If the selected unit's RDY is high: capture that unit's result into rsp_result and its exception into rsp_exception; rsp_timeout=0; go to RESP.
    - Else, if counter==TIMEOUT-1: rsp_result=0, rsp_exception=1, rsp_timeout=1; go to RESP.
    - The non-selected unit's RDY and result are ignored.
  - RESP:
    - rsp_valid=1; all rsp_* outputs held stable until rsp_ack.
    - On rsp_ack go to IDLE; rsp_valid drops the next cycle.
    - A new request cannot be accepted in the same cycle as the ack.
- Operand hold: unit_operandA/B stay constant from START until the next accepted request. They are not cleared on return to IDLE, so the units see stable inputs through RESP.
- rsp_tag and rsp_is_div are copied from the latched request when entering RESP.
- Requests while busy: ignored. The requester must hold its request until it sees req_ready.
- Latency:
  - Request accepted at edge 0; start pulse during cycle 1.
  - If the unit raises RDY in cycle k (k≥2), rsp_valid is high from cycle k+1.
- No combinational path from req_* to ctrl_* or rsp_*. req_ready and busy are decoded directly from state.

Test Plan:
- Multiply 6×7, tag=3, with a unit model whose RDY rises 17 cycles after ctrl_MULT -> exactly one ctrl_MULT pulse; rsp_valid after 18 cycles; rsp_result=42, rsp_tag=3, rsp_is_div=0, rsp_exception=0.
- Divide 100/7 with the divider model raising RDY after 33 cycles -> ctrl_DIV pulse only; rsp_result=14, rsp_is_div=1. A spurious mult_resultRDY during WAIT is ignored.
- req_mult and req_div both high in IDLE -> multiply performed; ctrl_DIV never asserted; req_ready=0 until the ack.
- Unit model never raises RDY, TIMEOUT=40 -> rsp_valid after 40 WAIT cycles with rsp_exception=1, rsp_timeout=1, rsp_result=0.
- Hold rsp_ack low 5 cycles in RESP while changing req_a/req_b and asserting req_mult -> rsp_* and unit_operand* unchanged; no new start; accepted only after ack and return to IDLE.
- Drive reset low for 1 cycle in WAIT -> immediate IDLE, busy=0, rsp_valid=0, no response. A following multiply 3×(-4) returns -12.
